// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default ROM/RAM region map for memory bus decoders
// Provides the controller state enum plus default address width, base, mask and wait constants.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} region_state_e;
  localparam int MEM_ADDR_W = 13;
  localparam int MEM_WAIT_W = 4;
  localparam logic [MEM_ADDR_W-1:0] RAM_BASE = 13'h1800;
  localparam logic [MEM_ADDR_W-1:0] RAM_MASK = 13'h1800;
  localparam logic [MEM_ADDR_W-1:0] ROM_BASE = 13'h0000;
  localparam logic [MEM_ADDR_W-1:0] ROM_MASK = 13'h0000;
  localparam logic [MEM_WAIT_W-1:0] RAM_WAIT = 4'd0;
  localparam logic [MEM_WAIT_W-1:0] ROM_WAIT = 4'd2;
endpackage

// File: rtl/mem_region_ctrl_if.sv
// mem_region_ctrl_if: request/response bundle between a CPU bus controller and the region controller
// master drives req_valid/req_addr/req_we; slave drives busy/sel/sel_we/ready/err.
interface mem_region_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int NUM_REG = 2
);
  logic req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic req_we;
  logic busy;
  logic [NUM_REG-1:0] sel;
  logic sel_we;
  logic ready;
  logic err;
  modport master(output req_valid, req_addr, req_we, input busy, sel, sel_we, ready, err);
  modport slave(input req_valid, req_addr, req_we, output busy, sel, sel_we, ready, err);
endinterface

// File: rtl/region_match.sv
// region_match: priority base/mask address decoder, lowest matching region wins
// Ports: addr, packed base/mask (slice 0 = LSBs) in; one-hot hit and hit_valid out. Purely combinational.
module region_match #(
  parameter int ADDR_W = 13,
  parameter int NUM_REG = 2
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [NUM_REG*ADDR_W-1:0] base,
  input  logic [NUM_REG*ADDR_W-1:0] mask,
  output logic [NUM_REG-1:0]        hit,
  output logic                      hit_valid
);
  logic [NUM_REG-1:0] match;
  for (genvar g = 0; g < NUM_REG; g++) begin : g_match
    assign match[g] = ((addr ^ base[g*ADDR_W +: ADDR_W]) & mask[g*ADDR_W +: ADDR_W]) == '0;
  end
  // isolating the lowest set bit gives the priority winner as a one-hot
  assign hit = match & (~match + NUM_REG'(1));
  assign hit_valid = |match;
endmodule

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: registered region decoder with per-region wait states and ready/err completion
// Ports: clk, rst_n (async active-low), bus (slave modport: req_valid/req_addr/req_we in; busy/sel/sel_we/ready/err out).
module mem_region_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int NUM_REG = 2,
  parameter int WAIT_W = MEM_WAIT_W,
  parameter logic [NUM_REG*ADDR_W-1:0] REGION_BASE = {ROM_BASE, RAM_BASE},
  parameter logic [NUM_REG*ADDR_W-1:0] REGION_MASK = {ROM_MASK, RAM_MASK},
  parameter logic [NUM_REG*WAIT_W-1:0] REGION_WAIT = {ROM_WAIT, RAM_WAIT}
) (
  input logic clk,
  input logic rst_n,
  mem_region_ctrl_if.slave bus
);
  region_state_e state, state_n;
  logic [NUM_REG-1:0] hit, sel_n;
  logic hit_valid, we_n, unm, unm_n;
  logic [WAIT_W-1:0] cnt, cnt_n, hit_wait;
  region_match #(.ADDR_W(ADDR_W), .NUM_REG(NUM_REG)) u_match (
    .addr(bus.req_addr),
    .base(REGION_BASE),
    .mask(REGION_MASK),
    .hit(hit),
    .hit_valid(hit_valid)
  );
  // hit is one-hot or zero, so OR-ing gated slices selects the winner's wait count (0 when unmapped)
  always_comb begin
    hit_wait = '0;
    for (int i = 0; i < NUM_REG; i++) hit_wait |= hit[i] ? REGION_WAIT[i*WAIT_W +: WAIT_W] : '0;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sel_n = bus.sel;
    we_n = bus.sel_we;
    unm_n = unm;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = ACCESS;
        sel_n = hit;
        we_n = bus.req_we;
        cnt_n = hit_wait;
        unm_n = !hit_valid;
      end
      ACCESS: begin
        state_n = cnt == '0 ? DONE : ACCESS;
        cnt_n = cnt == '0 ? cnt : cnt - WAIT_W'(1);
      end
      DONE: begin
        state_n = IDLE;
        sel_n = '0;
        we_n = 1'b0;
        unm_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.sel <= '0;
      bus.sel_we <= 1'b0;
      unm <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.sel <= sel_n;
      bus.sel_we <= we_n;
      unm <= unm_n;
    end
  end
  // decoded purely from registered state, so no input reaches an output combinationally
  assign bus.busy = state != IDLE;
  assign bus.ready = state == DONE;
  assign bus.err = state == DONE && unm;
endmodule

// File: tb/tb_mem_region_ctrl.sv
// tb_mem_region_ctrl: directed bench with a latency-level reference model for two controller configurations
module tb_mem_region_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  mem_region_ctrl_if #(.ADDR_W(13), .NUM_REG(2)) if0 ();
  mem_region_ctrl_if #(.ADDR_W(13), .NUM_REG(1)) if1 ();
  mem_region_ctrl u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  mem_region_ctrl #(
    .ADDR_W(13), .NUM_REG(1), .WAIT_W(4),
    .REGION_BASE(13'h1800), .REGION_MASK(13'h1800), .REGION_WAIT(4'd15)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  logic [1:0] o_sel [2];
  logic o_busy [2], o_we [2], o_rdy [2], o_err [2];
  logic i_v [2], i_we [2];
  logic [12:0] i_a [2];
  assign o_sel[0] = if0.sel;
  assign o_sel[1] = {1'b0, if1.sel};
  assign o_busy[0] = if0.busy;
  assign o_busy[1] = if1.busy;
  assign o_we[0] = if0.sel_we;
  assign o_we[1] = if1.sel_we;
  assign o_rdy[0] = if0.ready;
  assign o_rdy[1] = if1.ready;
  assign o_err[0] = if0.err;
  assign o_err[1] = if1.err;
  assign i_v[0] = if0.req_valid;
  assign i_v[1] = if1.req_valid;
  assign i_a[0] = if0.req_addr;
  assign i_a[1] = if1.req_addr;
  assign i_we[0] = if0.req_we;
  assign i_we[1] = if1.req_we;
  int nreg [2] = '{2, 1};
  logic [12:0] rb [2][2] = '{'{13'h1800, 13'h0000}, '{13'h1800, 13'h0000}};
  logic [12:0] rm [2][2] = '{'{13'h1800, 13'h0000}, '{13'h1800, 13'h0000}};
  int rw [2][2] = '{'{0, 2}, '{15, 0}};
  logic m_busy [2] = '{1'b0, 1'b0};
  logic m_we [2] = '{1'b0, 1'b0};
  logic m_unm [2] = '{1'b0, 1'b0};
  logic [1:0] m_sel [2] = '{2'b00, 2'b00};
  int m_age [2] = '{0, 0};
  int m_w [2] = '{0, 0};
  function automatic int winner(int d, logic [12:0] a);
    for (int r = 0; r < nreg[d]; r++) if ((a & rm[d][r]) == (rb[d][r] & rm[d][r])) return r;
    return -1;
  endfunction
  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask
  // model: an access lasts W+2 cycles after the accept edge, ready in the last one
  always @(posedge clk or negedge rst_n) begin
    int w;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_busy[d] <= 1'b0;
        m_sel[d] <= 2'b00;
        m_we[d] <= 1'b0;
        m_unm[d] <= 1'b0;
        m_age[d] <= 0;
        m_w[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          if (i_v[d]) begin
            w = winner(d, i_a[d]);
            m_busy[d] <= 1'b1;
            m_age[d] <= 0;
            m_we[d] <= i_we[d];
            m_unm[d] <= w < 0;
            if (w < 0) begin
              m_sel[d] <= 2'b00;
              m_w[d] <= 0;
            end else begin
              m_sel[d] <= 2'(1 << w);
              m_w[d] <= rw[d][w];
            end
          end
        end else if (m_age[d] == m_w[d] + 1) m_busy[d] <= 1'b0;
        else m_age[d] <= m_age[d] + 1;
      end
    end
  end
  always @(negedge clk) begin
    logic e_rdy;
    for (int d = 0; d < 2; d++) begin
      e_rdy = m_busy[d] && m_age[d] == m_w[d] + 1;
      chk("busy", d, 32'(o_busy[d]), 32'(m_busy[d]));
      chk("sel", d, 32'(o_sel[d]), m_busy[d] ? 32'(m_sel[d]) : 32'd0);
      chk("sel_we", d, 32'(o_we[d]), m_busy[d] ? 32'(m_we[d]) : 32'd0);
      chk("ready", d, 32'(o_rdy[d]), 32'(e_rdy));
      chk("err", d, 32'(o_err[d]), 32'(e_rdy && m_unm[d]));
      chk("onehot", d, 32'($onehot0(o_sel[d])), 32'd1);
    end
  end
  task automatic drive(int d, logic v, logic [12:0] a, logic w);
    if (d == 0) begin
      if0.req_valid = v;
      if0.req_addr = a;
      if0.req_we = w;
    end else begin
      if1.req_valid = v;
      if1.req_addr = a;
      if1.req_we = w;
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(int d, logic [12:0] a, logic w);
    drive(d, 1'b1, a, w);
    cyc(1);
    drive(d, 1'b0, 13'h0AAA, ~w);
  endtask
  task automatic wait_idle(int d);
    int k = 0;
    while (o_busy[d] && k < 40) begin
      cyc(1);
      k++;
    end
    chk("idle_timeout", d, 32'(o_busy[d]), 32'd0);
    cyc(1);
  endtask
  initial begin
    int nrdy;
    drive(0, 1'b0, 13'h0, 1'b0);
    drive(1, 1'b0, 13'h0, 1'b0);
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("rst_sel", 0, 32'(o_sel[0]), 32'd0);
    chk("rst_ready", 1, 32'(o_rdy[1]), 32'd0);
    rst_n = 1'b1;
    cyc(1);
    req(0, 13'h1A00, 1'b0);
    chk("ram_sel", 0, 32'(o_sel[0]), 32'd1);
    chk("ram_we", 0, 32'(o_we[0]), 32'd0);
    chk("ram_rdy_early", 0, 32'(o_rdy[0]), 32'd0);
    cyc(1);
    chk("ram_rdy", 0, 32'(o_rdy[0]), 32'd1);
    chk("ram_err", 0, 32'(o_err[0]), 32'd0);
    cyc(1);
    chk("ram_busy_end", 0, 32'(o_busy[0]), 32'd0);
    cyc(1);
    req(0, 13'h1FFF, 1'b1);
    chk("wr_we", 0, 32'(o_we[0]), 32'd1);
    wait_idle(0);
    req(0, 13'h0400, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("rom_sel", 0, 32'(o_sel[0]), 32'd2);
      chk("rom_rdy", 0, 32'(o_rdy[0]), 32'(k == 4));
      if (k < 4) cyc(1);
    end
    cyc(1);
    chk("rom_busy_end", 0, 32'(o_busy[0]), 32'd0);
    cyc(1);
    req(0, 13'h17FF, 1'b0);
    chk("bnd_17ff", 0, 32'(o_sel[0]), 32'd2);
    wait_idle(0);
    req(0, 13'h1800, 1'b0);
    chk("bnd_1800", 0, 32'(o_sel[0]), 32'd1);
    wait_idle(0);
    req(0, 13'h0400, 1'b0);
    drive(0, 1'b1, 13'h1800, 1'b1);
    nrdy = 0;
    for (int k = 2; k <= 8; k++) begin
      cyc(1);
      if (k == 3) drive(0, 1'b0, 13'h0, 1'b0);
      if (k <= 4) chk("rej_sel", 0, 32'(o_sel[0]), 32'd2);
      nrdy += int'(o_rdy[0]);
    end
    chk("rej_pulses", 0, 32'(nrdy), 32'd1);
    wait_idle(0);
    req(1, 13'h0000, 1'b0);
    chk("un_sel", 1, 32'(o_sel[1]), 32'd0);
    chk("un_rdy_early", 1, 32'(o_rdy[1]), 32'd0);
    cyc(1);
    chk("un_rdy", 1, 32'(o_rdy[1]), 32'd1);
    chk("un_err", 1, 32'(o_err[1]), 32'd1);
    wait_idle(1);
    req(1, 13'h1800, 1'b1);
    cyc(15);
    chk("w15_rdy_early", 1, 32'(o_rdy[1]), 32'd0);
    chk("w15_sel", 1, 32'(o_sel[1]), 32'd1);
    cyc(1);
    chk("w15_rdy", 1, 32'(o_rdy[1]), 32'd1);
    chk("w15_err", 1, 32'(o_err[1]), 32'd0);
    wait_idle(1);
    req(0, 13'h0400, 1'b0);
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(o_busy[0]), 32'd0);
    chk("arst_sel", 0, 32'(o_sel[0]), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    nrdy = 0;
    repeat (6) begin
      cyc(1);
      nrdy += int'(o_rdy[0]);
    end
    chk("arst_no_ready", 0, 32'(nrdy), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
